// File: rtl/peripheral_spram_pipelined_tl.sv
// Single-port SRAM with byte-lane writes, request/grant handshake and a 1- or 2-cycle response pipeline.
// An optional post-reset sequencer zero-fills the array before the first grant.
module peripheral_spram_pipelined_tl #(
  parameter int PLEN       = 64,
  parameter int XLEN       = 64,
  parameter int AW         = 10,
  parameter int READ_LAT   = 1,
  parameter int READ_FIRST = 1,
  parameter int CLEAR_INIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [PLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   data_i,
  output logic              rvalid_o,
  output logic [XLEN-1:0]   data_o,
  output logic              err_o,
  output logic              init_done_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              fill_we;

  logic [XLEN-1:0]   mem_q [DEPTH];

  logic              accept;
  logic [AW-1:0]     idx;
  logic [PLEN-1:0]   hi_bits;
  logic              oor;
  logic              wr_en;
  logic [XLEN-1:0]   old_word;
  logic [XLEN-1:0]   merged;
  logic [XLEN-1:0]   resp_data;

  logic              v1_q;
  logic              e1_q;
  logic [XLEN-1:0]   d1_q;

  // Handshake: a request is taken on any rising edge where req_i and gnt_o are both high;
  // each taken request produces exactly one rvalid_o pulse READ_LAT cycles later, in order.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        fill_we = 1'b1;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_q == '1) state_d = ST_RUN;
      end
      default: ;
    endcase
    gnt_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= (CLEAR_INIT != 0) ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign init_done_o = gnt_q;

  // Any address bit above the word index makes the access out of range.
  assign accept  = req_i & gnt_q;
  assign idx     = addr_i[OFF+AW-1:OFF];
  assign hi_bits = addr_i >> (OFF + AW);
  assign oor     = |hi_bits;
  assign wr_en   = accept & we_i & ~oor;

  always_comb begin
    old_word = mem_q[idx];
    merged   = old_word;
    for (int n = 0; n < NB; n++) begin
      if (be_i[n]) merged[8*n +: 8] = data_i[8*n +: 8];
    end
    if (oor) begin
      resp_data = '0;
    end else if (we_i && (READ_FIRST == 0)) begin
      resp_data = merged;
    end else begin
      resp_data = old_word;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= merged;
    end
  end

  // Data and error only load on an accepted request so they hold between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      e1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        e1_q <= oor;
        d1_q <= resp_data;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic            v2_q;
      logic            e2_q;
      logic [XLEN-1:0] d2_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v2_q <= 1'b0;
          e2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) begin
            e2_q <= e1_q;
            d2_q <= d1_q;
          end
        end
      end

      assign rvalid_o = v2_q;
      assign err_o    = e2_q;
      assign data_o   = d2_q;
    end else begin : g_lat1
      assign rvalid_o = v1_q;
      assign err_o    = e1_q;
      assign data_o   = d1_q;
    end
  endgenerate

endmodule
